alu_issue_ctrl: RTL and testbench

Multi-cycle issue controller that drives the datapath ALU from the instruction side. It accepts one 16-bit instruction per transaction over a valid/ready handshake and decodes it into the ALU opcode and operands. It holds the 16x16 register file and the 5-bit processor status register (PSR). It captures the ALU result and flags, then writes the result back to the register file and the flags to the PSR.

---
 rtl/alu_issue_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue controller. It decodes one 16-bit instruction
// per transaction, drives the external ALU, and writes the result back to the
// 16x16 register file and the 5-bit PSR.
// Optional build macro ALU_CTRL_FAST_EN: removes the READ state, and the ALU
// inputs are then driven combinationally from the decode during EXEC.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] inst,
    input  logic        inst_valid,
    output logic        inst_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [7:0]  alu_op,
    input  logic [15:0] alu_c,
    input  logic [4:0]  alu_flags,
    output logic [4:0]  psr,
    output logic        done,
    output logic        illegal,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int unsigned DW    = 16;
    localparam int unsigned NREGS = 16;
    localparam int unsigned FW    = 5;

    localparam logic [1:0] IDLE = 2'd0;
`ifndef ALU_CTRL_FAST_EN
    localparam logic [1:0] READ = 2'd1;
`endif
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] WB   = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [DW-1:0] inst_q;
    logic [DW-1:0] rf [NREGS];
    logic [DW-1:0] c_q;
    logic [FW-1:0] flags_q;
    logic [DW-1:0] alu_a_q;
    logic [DW-1:0] alu_b_q;
    logic [7:0]    alu_op_q;

    logic [3:0]    op_hi;
    logic [3:0]    op_lo;
    logic [3:0]    rd;
    logic [3:0]    rs;
    logic          reg_form;
    logic          imm_form;
    logic          is_cmp;
    logic          dec_legal;
    logic          dec_wr;
    logic [DW-1:0] dec_a;
    logic [DW-1:0] dec_b;

    logic          accept;
    logic          load_alu;
    logic          capture;
    logic          commit;
    logic          done_nx;
    logic          illegal_nx;

    // Decode of the accepted instruction; operands read from the current register file
    always_comb begin
        op_hi    = inst_q[15:12];
        rd       = inst_q[11:8];
        op_lo    = inst_q[7:4];
        rs       = inst_q[3:0];
        reg_form = 1'b0;
        imm_form = 1'b0;
        if (op_hi == 4'b0000) begin
            case (op_lo)
                4'b0101, 4'b0110, 4'b1001, 4'b1011,
                4'b0001, 4'b0010, 4'b0011: reg_form = 1'b1;
                default:                   reg_form = 1'b0;
            endcase
        end
        case (op_hi)
            4'b0101, 4'b0110, 4'b1001, 4'b1011: imm_form = 1'b1;
            default:                            imm_form = 1'b0;
        endcase
        is_cmp    = (reg_form && (op_lo == 4'b1011)) || (op_hi == 4'b1011);
        dec_legal = reg_form || imm_form;
        dec_wr    = dec_legal && !is_cmp;
        dec_a     = rf[rd];
        dec_b     = imm_form ? {8'h00, inst_q[7:0]} : rf[rs];
    end

    // Next-state and per-state control strobes
    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        load_alu   = 1'b0;
        capture    = 1'b0;
        commit     = 1'b0;
        done_nx    = 1'b0;
        illegal_nx = 1'b0;
        case (state)
            IDLE: begin
                if (inst_valid) begin
                    accept = 1'b1;
`ifdef ALU_CTRL_FAST_EN
                    state_nx = EXEC;
`else
                    state_nx = READ;
`endif
                end
            end
`ifndef ALU_CTRL_FAST_EN
            READ: begin
                load_alu = 1'b1;
                state_nx = EXEC;
            end
`endif
            EXEC: begin
`ifdef ALU_CTRL_FAST_EN
                load_alu = 1'b1;
`endif
                capture    = 1'b1;
                done_nx    = dec_legal;
                illegal_nx = !dec_legal;
                state_nx   = WB;
            end
            WB: begin
                commit   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Instruction capture, ALU operand latches, result capture and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q   <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            c_q      <= '0;
            flags_q  <= '0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            done    <= done_nx;
            illegal <= illegal_nx;
            if (accept) inst_q <= inst;
            if (load_alu) begin
                alu_a_q  <= dec_a;
                alu_b_q  <= dec_b;
                alu_op_q <= {op_hi, op_lo};
            end
            if (capture) begin
                c_q     <= alu_c;
                flags_q <= alu_flags;
            end
        end
    end

    // Register file and PSR writeback; reset aborts any pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
            psr <= '0;
        end else if (commit && dec_legal) begin
            psr <= flags_q;
            if (dec_wr) rf[rd] <= c_q;
        end
    end

`ifdef ALU_CTRL_FAST_EN
    // Fast build: decode feeds the ALU directly in EXEC, latched copy held elsewhere
    always_comb begin
        alu_a  = (state == EXEC) ? dec_a : alu_a_q;
        alu_b  = (state == EXEC) ? dec_b : alu_b_q;
        alu_op = (state == EXEC) ? {op_hi, op_lo} : alu_op_q;
    end
`else
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
`endif

    assign inst_ready = (state == IDLE);
    assign dbg_data   = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl with a behavioural register-file/PSR model.
module tb_alu_issue_ctrl;

`ifdef ALU_CTRL_FAST_EN
    localparam int EXEC_K = 1;
`else
    localparam int EXEC_K = 2;
`endif
    localparam int WB_K = EXEC_K + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [7:0]  alu_op;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic        done;
    logic        illegal;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] ref_rf [16];
    logic [4:0]  ref_psr;

    alu_issue_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_c      (alu_c),
        .alu_flags  (alu_flags),
        .psr        (psr),
        .done       (done),
        .illegal    (illegal),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    // External ALU: returns {Z, C, F, L, N, result}
    function automatic logic [20:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [7:0] op);
        logic [3:0]  kind;
        logic [16:0] s;
        logic [15:0] c;
        logic        z, cy, f, l, n;
        kind = (op[7:4] == 4'h0) ? op[3:0] : op[7:4];
        c = 16'hA5A5; z = 1'b1; cy = 1'b1; f = 1'b1; l = 1'b1; n = 1'b1;
        case (kind)
            4'h5, 4'h6: begin
                s = {1'b0, a} + {1'b0, b};
                c = s[15:0]; z = (c == 16'h0); cy = s[16];
                f = (a[15] == b[15]) && (c[15] != a[15]); l = 1'b0; n = 1'b0;
            end
            4'h9: begin
                c = a - b; z = (c == 16'h0); cy = (a < b);
                f = (a[15] != b[15]) && (c[15] != a[15]); l = 1'b0; n = 1'b0;
            end
            4'hB: begin
                c = a - b; z = (a == b); cy = 1'b0; f = 1'b0;
                l = (a < b); n = ($signed(a) < $signed(b));
            end
            4'h1: begin c = a & b; z = (c == 16'h0); cy = 1'b0; f = 1'b0; l = 1'b0; n = 1'b0; end
            4'h2: begin c = a | b; z = (c == 16'h0); cy = 1'b0; f = 1'b0; l = 1'b0; n = 1'b0; end
            4'h3: begin c = a ^ b; z = (c == 16'h0); cy = 1'b0; f = 1'b0; l = 1'b0; n = 1'b0; end
            default: ;
        endcase
        return {z, cy, f, l, n, c};
    endfunction

    always_comb {alu_flags, alu_c} = alu_fn(alu_a, alu_b, alu_op);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit spec_legal(input logic [15:0] w);
        if (w[15:12] == 4'h0)
            return w[7:4] inside {4'h5, 4'h6, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3};
        return w[15:12] inside {4'h5, 4'h6, 4'h9, 4'hB};
    endfunction

    function automatic bit spec_imm(input logic [15:0] w);
        return w[15:12] inside {4'h5, 4'h6, 4'h9, 4'hB};
    endfunction

    function automatic bit spec_cmp(input logic [15:0] w);
        return (w[15:12] == 4'hB) || (w[15:12] == 4'h0 && w[7:4] == 4'hB);
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < 16; i++) ref_rf[i] = 16'h0;
        ref_psr = 5'h0;
    endtask

    // Architectural effect of one retired instruction
    task automatic ref_commit(input logic [15:0] w);
        logic [15:0] a, b;
        logic [20:0] r;
        a = ref_rf[w[11:8]];
        b = spec_imm(w) ? {8'h00, w[7:0]} : ref_rf[w[3:0]];
        r = alu_fn(a, b, {w[15:12], w[7:4]});
        if (spec_legal(w)) begin
            ref_psr = r[20:16];
            if (!spec_cmp(w)) ref_rf[w[11:8]] = r[15:0];
        end
    endtask

    task automatic peek(input logic [3:0] addr, output logic [15:0] data);
        dbg_addr = addr;
        #1;
        data = dbg_data;
    endtask

    // Issue one instruction; rst_k>0 asserts reset during that cycle after accept
    task automatic issue(input logic [15:0] w, input int rst_k, input bit hold);
        logic [15:0] ea, eb, d;
        logic [7:0]  eop;
        bit          legal;
        logic [3:0]  rd;
        rd    = w[11:8];
        legal = spec_legal(w);
        ea    = ref_rf[rd];
        eb    = spec_imm(w) ? {8'h00, w[7:0]} : ref_rf[w[3:0]];
        eop   = {w[15:12], w[7:4]};
        chk("ready_idle", 32'(inst_ready), 32'(1));
        inst = w;
        inst_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= WB_K; k++) begin
            @(negedge clk);
            if (hold) inst = 16'($urandom);
            else      inst_valid = 1'b0;
            chk("ready_busy", 32'(inst_ready), 32'(0));
            if (k == EXEC_K) begin
                chk("alu_a", 32'(alu_a), 32'(ea));
                chk("alu_b", 32'(alu_b), 32'(eb));
                chk("alu_op", 32'(alu_op), 32'(eop));
            end
            if (k == WB_K) begin
                chk("done_wb", 32'(done), 32'(legal));
                chk("illegal_wb", 32'(illegal), 32'(!legal));
                chk("alu_a_hold", 32'(alu_a), 32'(ea));
                peek(rd, d);
                chk("dbg_old", 32'(d), 32'(ref_rf[rd]));
                inst_valid = 1'b0;
            end else begin
                chk("done_early", 32'(done), 32'(0));
                chk("illegal_early", 32'(illegal), 32'(0));
            end
            if (k == rst_k) begin
                inst_valid = 1'b0;
                reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                ref_reset();
                @(negedge clk);
                chk("ready_after_rst", 32'(inst_ready), 32'(1));
                chk("done_after_rst", 32'(done), 32'(0));
                chk("illegal_after_rst", 32'(illegal), 32'(0));
                chk("psr_after_rst", 32'(psr), 32'(0));
                chk("alu_a_after_rst", 32'(alu_a), 32'(0));
                return;
            end
        end
        ref_commit(w);
        @(negedge clk);
        chk("ready_again", 32'(inst_ready), 32'(1));
        chk("done_off", 32'(done), 32'(0));
        chk("illegal_off", 32'(illegal), 32'(0));
        chk("psr", 32'(psr), 32'(ref_psr));
        peek(rd, d);
        chk("rf_rd", 32'(d), 32'(ref_rf[rd]));
    endtask

    function automatic logic [15:0] rand_inst();
        logic [15:0] w;
        logic [3:0]  lo, hi;
        w = 16'($urandom);
        case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
                case ($urandom_range(0, 6))
                    0: lo = 4'h5; 1: lo = 4'h6; 2: lo = 4'h9; 3: lo = 4'hB;
                    4: lo = 4'h1; 5: lo = 4'h2; default: lo = 4'h3;
                endcase
                w[15:12] = 4'h0;
                w[7:4]   = lo;
            end
            4, 5, 6, 7: begin
                case ($urandom_range(0, 3))
                    0: hi = 4'h5; 1: hi = 4'h6; 2: hi = 4'h9; default: hi = 4'hB;
                endcase
                w[15:12] = hi;
            end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int          rk;
        reset = 1'b1;
        inst = 16'h0;
        inst_valid = 1'b0;
        dbg_addr = 4'h0;
        ref_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(inst_ready), 32'(1));
        chk("rst_alu_a", 32'(alu_a), 32'(0));
        chk("rst_alu_b", 32'(alu_b), 32'(0));
        chk("rst_alu_op", 32'(alu_op), 32'(0));
        chk("rst_psr", 32'(psr), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_illegal", 32'(illegal), 32'(0));
        for (int i = 0; i < 16; i++) begin
            peek(4'(i), d);
            chk("rst_rf", 32'(d), 32'(0));
        end

        // Directed sequence
        issue(16'h517F, 0, 1'b0);
        peek(4'h1, d); chk("addi_r1", 32'(d), 32'h007F);
        chk("addi_psr", 32'(psr), 32'(5'b00000));
        issue(16'h5201, 0, 1'b0);
        issue(16'h0152, 0, 1'b0);
        peek(4'h1, d); chk("add_r1", 32'(d), 32'h0080);
        peek(4'h2, d); chk("add_r2", 32'(d), 32'h0001);
        chk("add_z", 32'(psr[4]), 32'(0));
        issue(16'h0191, 0, 1'b0);
        peek(4'h1, d); chk("sub_r1", 32'(d), 32'h0000);
        chk("sub_psr", 32'(psr), 32'(5'b10000));
        issue(16'hB205, 0, 1'b0);
        peek(4'h2, d); chk("cmpi_r2", 32'(d), 32'h0001);
        chk("cmpi_psr", 32'(psr), 32'(5'b00011));
        issue(16'h8000, 0, 1'b1);
        chk("shift_psr", 32'(psr), 32'(5'b00011));
        issue(16'h5310, EXEC_K, 1'b0);
        peek(4'h3, d); chk("abort_r3", 32'(d), 32'h0000);

        // Randomized traffic with occasional holds and resets
        for (int n = 0; n < 250; n++) begin
            rk = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, WB_K)) : 0;
            issue(rand_inst(), rk, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        for (int i = 0; i < 16; i++) begin
            peek(4'(i), d);
            chk("final_rf", 32'(d), 32'(ref_rf[i]));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
